alu_arbiter: RTL and testbench

Shares one instance of the team's 32-bit `alu` between `NUM_REQ` requesters (e.g. CNN layer controllers, address generators) using round-robin arbitration with valid/ready handshakes on both sides. Each accepted request latches its operands and opcode, runs one ALU evaluation, and returns a registered response tagged with the requester index. It sits between the compute-control layer and the shared arithmetic resource, and it is the only module that drives the ALU's inputs.

---
 rtl/alu_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU between NUM_REQ valid/ready requesters.
// Optional feature macro: ALU_ARB_ILLEGAL_OP_CHECK_EN (flags unsupported opcodes via rsp_err).

module alu (
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] out,
  output logic        zero,
  output logic        overflow
);
  logic [31:0] sum;
  logic [31:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    out      = '0;
    overflow = 1'b0;
    case (op)
      4'b0000: out = a & b;
      4'b0001: out = a | b;
      4'b0010: begin
        out      = sum;
        overflow = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      4'b0110: begin
        out      = diff;
        overflow = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      4'b0111: out = {31'b0, (a == b)};
      4'b1100: out = ~(a | b);
      default: out = '0;
    endcase
  end

  assign zero = (out == '0);
endmodule

module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*4-1:0]  req_op,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_out,
  output logic                  rsp_zero,
  output logic                  rsp_overflow,
  output logic                  rsp_err,
  output logic [15:0]           op_count
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   rr_ptr_reg;
  logic [ID_W-1:0]   id_reg;
  logic [3:0]        op_reg;
  logic [31:0]       a_reg, b_reg;
  logic              rsp_valid_reg, rsp_zero_reg, rsp_overflow_reg, rsp_err_reg;
  logic [ID_W-1:0]   rsp_id_reg;
  logic [31:0]       rsp_out_reg;
  logic [15:0]       op_count_reg;

  logic [3:0]        op_arr [NUM_REQ];
  logic [31:0]       a_arr  [NUM_REQ];
  logic [31:0]       b_arr  [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign op_arr[gi] = req_op[4*gi +: 4];
      assign a_arr[gi]  = req_a[32*gi +: 32];
      assign b_arr[gi]  = req_b[32*gi +: 32];
    end
  endgenerate

  // Rotating priority search starting at rr_ptr_reg.
  logic            found;
  logic [ID_W-1:0] grant_id;
  int              idx;

  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[ID_W'(idx)]) begin
        found    = 1'b1;
        grant_id = ID_W'(idx);
      end
    end
  end

  logic accept;
  assign accept    = (state_reg == IDLE) && found;
  assign req_ready = (accept && !rst) ? (NUM_REQ'(1) << grant_id) : '0;

  logic [31:0] alu_out;
  logic        alu_zero, alu_overflow;

  alu u_alu (
    .op       (op_reg),
    .a        (a_reg),
    .b        (b_reg),
    .out      (alu_out),
    .zero     (alu_zero),
    .overflow (alu_overflow)
  );

  logic [31:0] res_out;
  logic        res_zero, res_overflow, res_err;

  always_comb begin
    res_out      = alu_out;
    res_zero     = alu_zero;
    res_overflow = alu_overflow;
    res_err      = 1'b0;
`ifdef ALU_ARB_ILLEGAL_OP_CHECK_EN
    case (op_reg)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: res_err = 1'b0;
      default: begin
        res_err      = 1'b1;
        res_out      = '0;
        res_zero     = 1'b0;
        res_overflow = 1'b0;
      end
    endcase
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg       <= '0;
      id_reg           <= '0;
      op_reg           <= '0;
      a_reg            <= '0;
      b_reg            <= '0;
      rsp_valid_reg    <= 1'b0;
      rsp_id_reg       <= '0;
      rsp_out_reg      <= '0;
      rsp_zero_reg     <= 1'b0;
      rsp_overflow_reg <= 1'b0;
      rsp_err_reg      <= 1'b0;
      op_count_reg     <= '0;
    end else begin
      if (accept) begin
        id_reg     <= grant_id;
        op_reg     <= op_arr[grant_id];
        a_reg      <= a_arr[grant_id];
        b_reg      <= b_arr[grant_id];
        rr_ptr_reg <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
      end
      if (state_reg == EXEC) begin
        rsp_valid_reg    <= 1'b1;
        rsp_id_reg       <= id_reg;
        rsp_out_reg      <= res_out;
        rsp_zero_reg     <= res_zero;
        rsp_overflow_reg <= res_overflow;
        rsp_err_reg      <= res_err;
      end
      // Handshake only counts while a response is actually pending.
      if (state_reg == RESP && rsp_ready) begin
        rsp_valid_reg <= 1'b0;
        op_count_reg  <= op_count_reg + 16'd1;
      end
    end
  end

  assign rsp_valid    = rsp_valid_reg;
  assign rsp_id       = rsp_id_reg;
  assign rsp_out      = rsp_out_reg;
  assign rsp_zero     = rsp_zero_reg;
  assign rsp_overflow = rsp_overflow_reg;
  assign rsp_err      = rsp_err_reg;
  assign op_count     = op_count_reg;
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter against a behavioural ALU/round-robin model.
// Honours ALU_ARB_ILLEGAL_OP_CHECK_EN the same way as the design.

module tb_alu_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*4-1:0] req_op;
  logic [N*32-1:0] req_a, req_b;
  logic [N-1:0]   req_ready;
  logic           rsp_valid, rsp_ready;
  logic [1:0]     rsp_id;
  logic [31:0]    rsp_out;
  logic           rsp_zero, rsp_overflow, rsp_err;
  logic [15:0]    op_count;

  int n_cmp = 0;
  int n_mis = 0;
  int model_ptr = 0;
  int model_count = 0;

  alu_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_a(req_a),
    .req_b(req_b), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_out(rsp_out), .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
    .rsp_err(rsp_err), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // {known, err, overflow, zero, out}; known=0 when the result is the raw ALU's business.
  function automatic logic [35:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, r;
    logic [31:0] o;
    logic ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 0;
    o = 0;
    ovf = 1'b0;
    case (op)
      4'b0000: o = a & b;
      4'b0001: o = a | b;
      4'b0010: begin r = sa + sb; o = r[31:0]; ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      4'b0110: begin r = sa - sb; o = r[31:0]; ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      4'b0111: o = (a == b) ? 32'd1 : 32'd0;
      4'b1100: o = ~(a | b);
      default: begin
`ifdef ALU_ARB_ILLEGAL_OP_CHECK_EN
        return {1'b1, 1'b1, 1'b0, 1'b0, 32'd0};
`else
        return {1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
`endif
      end
    endcase
    return {1'b1, 1'b0, ovf, (o == 32'd0), o};
  endfunction

  function automatic int model_pick(input logic [N-1:0] mask);
    for (int k = 0; k < N; k++) begin
      if (mask[(model_ptr + k) % N]) return (model_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[4*i +: 4]  = op;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  function automatic logic [3:0] rand_op();
    logic [3:0] legal [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
`ifdef ALU_ARB_ILLEGAL_OP_CHECK_EN
    if ($urandom_range(0, 7) == 0) return 4'($urandom_range(0, 15));
`endif
    return legal[$urandom_range(0, 5)];
  endfunction

  task automatic rand_reqs();
    logic [31:0] a;
    for (int i = 0; i < N; i++) begin
      a = $urandom;
      set_req(i, rand_op(), a, ($urandom_range(0, 3) == 0) ? a : 32'($urandom));
    end
  endtask

  // Entered just after a rising edge with the DUT idle; leaves it idle the same way.
  task automatic run_txn(input logic [N-1:0] mask, input int stall);
    int g;
    logic [3:0] op;
    logic [31:0] a, b;
    logic [35:0] e;
    g = model_pick(mask);
    op = req_op[4*g +: 4];
    a = req_a[32*g +: 32];
    b = req_b[32*g +: 32];
    e = ref_alu(op, a, b);
    req_valid = mask;
    rsp_ready = 1'b0;
    @(negedge clk);
    check_val("grant", 32'(req_ready), 32'(1 << g));
    @(posedge clk); #1;
    model_ptr = (g + 1) % N;
    rand_reqs();
    @(negedge clk);
    check_val("exec_ready", 32'(req_ready), 32'd0);
    check_val("exec_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    $display("txn id=%0d op=%b a=%08h b=%08h out=%08h z=%0b v=%0b e=%0b stall=%0d",
             g, op, a, b, rsp_out, rsp_zero, rsp_overflow, rsp_err, stall);
    for (int s = 0; s <= stall; s++) begin
      check_val("rsp_valid", 32'(rsp_valid), 32'd1);
      check_val("rsp_id", 32'(rsp_id), 32'(g));
      check_val("rsp_err", 32'(rsp_err), 32'(e[34]));
      if (e[35]) begin
        check_val("rsp_out", rsp_out, e[31:0]);
        check_val("rsp_zero", 32'(rsp_zero), 32'(e[32]));
        check_val("rsp_ovf", 32'(rsp_overflow), 32'(e[33]));
      end
      if (s > 0) check_val("stall_ready", 32'(req_ready), 32'd0);
      if (s < stall) begin
        @(posedge clk); #1;
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = '0;
    model_count = (model_count + 1) % 65536;
    check_val("op_count", 32'(op_count), 32'(model_count));
    check_val("done_valid", 32'(rsp_valid), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ready"}, 32'(req_ready), 32'd0);
    check_val({tag, "_valid"}, 32'(rsp_valid), 32'd0);
    check_val({tag, "_id"}, 32'(rsp_id), 32'd0);
    check_val({tag, "_out"}, rsp_out, 32'd0);
    check_val({tag, "_flags"}, {29'd0, rsp_zero, rsp_overflow, rsp_err}, 32'd0);
    check_val({tag, "_count"}, 32'(op_count), 32'd0);
  endtask

  initial begin
    int last, ngr;
    rst = 1'b1;
    req_valid = '0;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    req_valid = '0;
    rst = 1'b0;
    @(posedge clk); #1;

    // Round robin with every requester held valid.
    rand_reqs();
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    last = 0;
    ngr = 0;
    for (int cyc = 0; cyc < 30 && ngr < 5; cyc++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        check_val("rr_onehot", 32'($countones(req_ready)), 32'd1);
        check_val("rr_grant", 32'(req_ready), 32'(1 << model_ptr));
        if (ngr > 0) check_val("rr_gap", 32'(cyc - last), 32'd3);
        $display("txn rr grant=%b cycle=%0d", req_ready, cyc);
        model_ptr = (model_ptr + 1) % N;
        last = cyc;
        ngr++;
      end
    end
    check_val("rr_grants", 32'(ngr), 32'd5);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    model_count = 5;
    check_val("rr_count", 32'(op_count), 32'(model_count));

    // rsp_ready while nothing is pending must not count.
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check_val("idle_ready_count", 32'(op_count), 32'(model_count));

    set_req(1, 4'b0010, 32'd5, 32'd7);
    run_txn(4'b0010, 0);
    set_req(0, 4'b0110, 32'h3, 32'h3);
    run_txn(4'b0001, 0);
    set_req(2, 4'b0010, 32'h7FFF_FFFF, 32'd1);
    run_txn(4'b0100, 1);
    set_req(3, 4'b0111, 32'h80F0_4021, 32'h80F0_4021);
    run_txn(4'b1000, 5);
    set_req(0, 4'b0011, 32'd1, 32'd1);
    run_txn(4'b0001, 0);

    for (int t = 0; t < 40; t++) begin
      logic [N-1:0] m;
      rand_reqs();
      m = 4'($urandom_range(1, 15));
      run_txn(m, $urandom_range(0, 2));
    end

    // Reset during EXEC discards the operation.
    set_req(1, 4'b0010, 32'd9, 32'd9);
    set_req(2, 4'b0001, 32'hF0, 32'h0F);
    req_valid = 4'b0010;
    @(posedge clk); #3;
    req_valid = 4'b0110;
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    @(posedge clk); #1;
    check_all_zero("rst_hold");
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;
    model_ptr = 0;
    model_count = 0;
    @(posedge clk); #1;
    check_val("rst_no_rsp", 32'(rsp_valid), 32'd0);
    run_txn(4'b0100, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis + 1);
    $fatal(1, "timeout");
  end
endmodule
